// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the CPU datapath: FETCH/EXEC/WB/HALT sequencing,
// subroutine depth tracking, and the optional retired-instruction counter (MCU_PERF_CNT_EN).
module multicycle_control_unit #(
  parameter int STACK_DEPTH = 8,
  parameter int DCW         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcodeFunc,
  input  logic        Cin,
  input  logic        Zin,
  output logic        pcEn,
  output logic        flagEn,
  output logic        push,
  output logic        pop,
  output logic        memWriteEn,
  output logic        regWriteEn,
  output logic        immAndmem,
  output logic        stm,
  output logic        ldm,
  output logic        branch,
  output logic        jmp,
  output logic        jsb,
  output logic [3:0]  aluOp,
  output logic        halted,
  output logic [15:0] instRetired
);

  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LDM, C_STM, C_SHIFT,
    C_BR, C_JMP, C_JSB, C_RET, C_NOP, C_ILL
  } cls_t;

  function automatic cls_t classify(input logic [4:0] op);
    cls_t c;
    casez (op)
      5'b00???: c = C_ALU_R;
      5'b01???: c = C_ALU_I;
      5'b10000: c = C_LDM;
      5'b10001: c = C_STM;
      5'b10010: c = C_SHIFT;
      5'b101??: c = C_BR;
      5'b11000: c = C_JMP;
      5'b11001: c = C_JSB;
      5'b11010: c = C_RET;
      5'b11011: c = C_NOP;
      default:  c = C_ILL;
    endcase
    return c;
  endfunction

  state_t         r_state, w_next;
  logic [4:0]     r_op;
  logic [DCW-1:0] r_depth, w_depth_nxt;

  cls_t           w_cls;
  logic           w_fetch_ill;
  logic           w_full, w_empty, w_taken;
  logic [3:0]     w_alu_op;
  logic           w_imm, w_stm, w_ldm, w_is_alu;

  assign w_cls       = classify(r_op);
  assign w_fetch_ill = (classify(opcodeFunc) == C_ILL);
  assign w_full      = (r_depth == DCW'(STACK_DEPTH));
  assign w_empty     = (r_depth == '0);

  // Branch condition is taken from the flags live in EXEC, selected by the low opcode bits.
  always_comb begin
    unique case (r_op[1:0])
      2'b00:   w_taken = Zin;
      2'b01:   w_taken = ~Zin;
      2'b10:   w_taken = Cin;
      default: w_taken = ~Cin;
    endcase
  end

  // Datapath selects shared by EXEC and WB so they stay stable across both cycles.
  always_comb begin
    w_alu_op = 4'b0000;
    w_imm    = 1'b0;
    w_stm    = 1'b0;
    w_ldm    = 1'b0;
    w_is_alu = 1'b0;
    case (w_cls)
      C_ALU_R: begin w_alu_op = {1'b0, r_op[2:0]}; w_is_alu = 1'b1; end
      C_ALU_I: begin w_alu_op = {1'b0, r_op[2:0]}; w_imm = 1'b1; w_is_alu = 1'b1; end
      C_SHIFT: begin w_alu_op = 4'b1000; w_is_alu = 1'b1; end
      C_LDM:   begin w_imm = 1'b1; w_ldm = 1'b1; end
      C_STM:   begin w_imm = 1'b1; w_stm = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_depth_nxt = r_depth;
    pcEn        = 1'b0;
    flagEn      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    memWriteEn  = 1'b0;
    regWriteEn  = 1'b0;
    immAndmem   = 1'b0;
    stm         = 1'b0;
    ldm         = 1'b0;
    branch      = 1'b0;
    jmp         = 1'b0;
    jsb         = 1'b0;
    aluOp       = 4'b0000;
    halted      = 1'b0;
    case (r_state)
      FETCH: w_next = w_fetch_ill ? HALT : EXEC;
      EXEC: begin
        aluOp     = w_alu_op;
        immAndmem = w_imm;
        stm       = w_stm;
        ldm       = w_ldm;
        case (w_cls)
          C_ALU_R, C_ALU_I, C_SHIFT: begin
            flagEn = 1'b1;
            w_next = WB;
          end
          C_LDM, C_STM: w_next = WB;
          C_BR: begin
            branch = w_taken;
            pcEn   = 1'b1;
            w_next = FETCH;
          end
          C_JMP: begin
            jmp    = 1'b1;
            pcEn   = 1'b1;
            w_next = FETCH;
          end
          C_JSB: begin
            if (w_full) begin
              w_next = HALT;
            end else begin
              jmp         = 1'b1;
              push        = 1'b1;
              pcEn        = 1'b1;
              w_depth_nxt = r_depth + DCW'(1);
              w_next      = FETCH;
            end
          end
          C_RET: begin
            if (w_empty) begin
              w_next = HALT;
            end else begin
              jsb         = 1'b1;
              pop         = 1'b1;
              pcEn        = 1'b1;
              w_depth_nxt = r_depth - DCW'(1);
              w_next      = FETCH;
            end
          end
          C_NOP: begin
            pcEn   = 1'b1;
            w_next = FETCH;
          end
          default: w_next = HALT;
        endcase
      end
      WB: begin
        aluOp      = w_alu_op;
        immAndmem  = w_imm;
        stm        = w_stm;
        ldm        = w_ldm;
        pcEn       = 1'b1;
        regWriteEn = w_is_alu | w_ldm;
        memWriteEn = w_stm;
        w_next     = FETCH;
      end
      HALT: halted = 1'b1;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_op    <= 5'b00000;
      r_depth <= '0;
    end else begin
      r_state <= w_next;
      r_depth <= w_depth_nxt;
      if (r_state == FETCH) r_op <= opcodeFunc;
    end
  end

`ifdef MCU_PERF_CNT_EN
  logic [15:0] r_inst_ret;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_inst_ret <= 16'h0000;
    else if (pcEn) r_inst_ret <= r_inst_ret + 16'h0001;
  end
  assign instRetired = r_inst_ret;
`else
  assign instRetired = 16'h0000;
`endif

endmodule
